// File: rtl/multicycle_control_unit_if.sv
// Signal bundle between the multicycle control unit and the datapath/memory side.
// master: the control unit (consumes instr/flags/mem_ready, drives all controls).
// slave:  datapath and shared memory (the reverse view).
interface multicycle_control_unit_if #(
    parameter int unsigned Width        = 32,
    parameter int unsigned ALUctrlWidth = 4
);
    logic [Width-1:0]        instr;
    logic                    EQ;
    logic                    LT;
    logic                    LTU;
    logic                    mem_ready;
    logic                    mem_req;
    logic                    Data_WE;
    logic [2:0]              MemSize;
    logic                    IRWrite;
    logic                    PCWrite;
    logic [1:0]              PCsrc;
    logic                    RegWrite;
    logic [1:0]              ResultSrc;
    logic                    ALUsrc;
    logic                    ALUAsrc;
    logic [ALUctrlWidth-1:0] ALUctrl;
    logic [2:0]              ImmSrc;
    logic                    PCJump;
    logic                    instr_retired;
    logic                    fault;
    logic [1:0]              fault_cause;

    modport master (
        input  instr, EQ, LT, LTU, mem_ready,
        output mem_req, Data_WE, MemSize, IRWrite, PCWrite, PCsrc, RegWrite, ResultSrc,
               ALUsrc, ALUAsrc, ALUctrl, ImmSrc, PCJump, instr_retired, fault, fault_cause
    );

    modport slave (
        output instr, EQ, LT, LTU, mem_ready,
        input  mem_req, Data_WE, MemSize, IRWrite, PCWrite, PCsrc, RegWrite, ResultSrc,
               ALUsrc, ALUAsrc, ALUctrl, ImmSrc, PCJump, instr_retired, fault, fault_cause
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: FETCH -> DECODE -> EXECUTE -> [MEMORY] -> [WRITEBACK].
// Handshakes with a shared instruction/data memory and traps on illegal opcodes or
// memory timeouts. TRAP is absorbing until rst.
module multicycle_control_unit #(
    parameter int unsigned Width        = 32,
    parameter int unsigned ALUctrlWidth = 4,
    parameter int unsigned MemTimeout   = 15
) (
    input logic                       clk,
    input logic                       rst,
    multicycle_control_unit_if.master bus
);
    localparam int unsigned    CntW     = $clog2(MemTimeout + 1);
    localparam logic [CntW-1:0] CntLimit = CntW'(MemTimeout);

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    localparam logic [ALUctrlWidth-1:0] AluAdd   = ALUctrlWidth'(0);
    localparam logic [ALUctrlWidth-1:0] AluSub   = ALUctrlWidth'(1);
    localparam logic [ALUctrlWidth-1:0] AluSll   = ALUctrlWidth'(2);
    localparam logic [ALUctrlWidth-1:0] AluSlt   = ALUctrlWidth'(3);
    localparam logic [ALUctrlWidth-1:0] AluSltu  = ALUctrlWidth'(4);
    localparam logic [ALUctrlWidth-1:0] AluXor   = ALUctrlWidth'(5);
    localparam logic [ALUctrlWidth-1:0] AluSrl   = ALUctrlWidth'(6);
    localparam logic [ALUctrlWidth-1:0] AluSra   = ALUctrlWidth'(7);
    localparam logic [ALUctrlWidth-1:0] AluOr    = ALUctrlWidth'(8);
    localparam logic [ALUctrlWidth-1:0] AluAnd   = ALUctrlWidth'(9);
    localparam logic [ALUctrlWidth-1:0] AluPassB = ALUctrlWidth'(10);

    localparam logic [2:0] ImmI    = 3'b000;
    localparam logic [2:0] ImmS    = 3'b001;
    localparam logic [2:0] ImmB    = 3'b010;
    localparam logic [2:0] ImmNone = 3'b011;
    localparam logic [2:0] ImmU    = 3'b100;
    localparam logic [2:0] ImmJ    = 3'b101;

    localparam logic [1:0] PcPlus4 = 2'b00;
    localparam logic [1:0] PcImm   = 2'b01;
    localparam logic [1:0] PcAlu   = 2'b10;

    localparam logic [1:0] ResAlu = 2'b00;
    localparam logic [1:0] ResMem = 2'b01;
    localparam logic [1:0] ResPc4 = 2'b10;

    localparam logic [1:0] CauseNone    = 2'b00;
    localparam logic [1:0] CauseIllegal = 2'b01;
    localparam logic [1:0] CauseMem     = 2'b10;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExecute,
        StMemory,
        StWriteback,
        StTrap
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [1:0]      cause_q, cause_d;

    logic [Width-1:0] instr_w;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic             is_r, is_store, illegal, taken;
    logic [ALUctrlWidth-1:0] alu_op;

    logic                    mem_req, data_we, ir_write, pc_write, reg_write;
    logic                    alu_src, alu_a_src, pc_jump, retired, fault;
    logic [2:0]              mem_size, imm_src;
    logic [1:0]              pc_src, result_src, fault_cause;
    logic [ALUctrlWidth-1:0] alu_ctrl;

    assign instr_w  = bus.instr;
    assign opcode   = instr_w[6:0];
    assign funct3   = instr_w[14:12];
    assign funct7   = instr_w[31:25];
    assign is_r     = (opcode == OpR);
    assign is_store = (opcode == OpStore);

    // Register fields are consumed by the datapath, not here.
    logic unused_instr;
    assign unused_instr = ^{instr_w[24:15], instr_w[11:7]};

    // Wait counter saturates at the limit instead of wrapping.
    assign cnt_inc = (cnt_q == CntLimit) ? cnt_q : cnt_q + 1'b1;

    // Legality check of the held instruction.
    always_comb begin
        illegal = 1'b0;
        case (opcode)
            OpR:      illegal = !((funct7 == 7'b0000000) || (funct7 == 7'b0100000));
            OpI, OpJal, OpJalr, OpLui, OpAuipc: illegal = 1'b0;
            OpLoad:   illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            OpStore:  illegal = (funct3 >= 3'b011);
            OpBranch: illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
            default:  illegal = 1'b1;
        endcase
    end

    // ALU operation for R-type and I-ALU; instr[30] only selects sub for R-type.
    always_comb begin
        alu_op = AluAdd;
        case (funct3)
            3'b000:  alu_op = (is_r && instr_w[30]) ? AluSub : AluAdd;
            3'b001:  alu_op = AluSll;
            3'b010:  alu_op = AluSlt;
            3'b011:  alu_op = AluSltu;
            3'b100:  alu_op = AluXor;
            3'b101:  alu_op = instr_w[30] ? AluSra : AluSrl;
            3'b110:  alu_op = AluOr;
            default: alu_op = AluAnd;
        endcase
    end

    // Branch condition from the ALU flags.
    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = bus.EQ;
            3'b001:  taken = !bus.EQ;
            3'b100:  taken = bus.LT;
            3'b101:  taken = !bus.LT;
            3'b110:  taken = bus.LTU;
            3'b111:  taken = !bus.LTU;
            default: taken = 1'b0;
        endcase
    end

    // Next-state, wait counter, trap cause and control outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cause_d     = cause_q;
        mem_req     = 1'b0;
        data_we     = 1'b0;
        mem_size    = 3'b010;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = PcPlus4;
        reg_write   = 1'b0;
        result_src  = ResAlu;
        alu_src     = 1'b0;
        alu_a_src   = 1'b0;
        alu_ctrl    = AluAdd;
        imm_src     = ImmNone;
        pc_jump     = 1'b0;
        retired     = 1'b0;
        fault       = 1'b0;
        fault_cause = cause_q;

        unique case (state_q)
            StFetch: begin
                mem_req = 1'b1;
                if (bus.mem_ready) begin
                    ir_write = 1'b1;
                    state_d  = StDecode;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CntLimit) begin
                        state_d = StTrap;
                        cause_d = CauseMem;
                    end
                end
            end
            StDecode: begin
                if (illegal) begin
                    state_d = StTrap;
                    cause_d = CauseIllegal;
                end else begin
                    state_d = StExecute;
                end
            end
            StExecute: begin
                case (opcode)
                    OpR: begin
                        alu_ctrl = alu_op;
                        state_d  = StWriteback;
                    end
                    OpI: begin
                        alu_ctrl = alu_op;
                        alu_src  = 1'b1;
                        imm_src  = ImmI;
                        state_d  = StWriteback;
                    end
                    OpLoad, OpStore: begin
                        alu_src = 1'b1;
                        imm_src = is_store ? ImmS : ImmI;
                        state_d = StMemory;
                    end
                    OpBranch: begin
                        alu_ctrl = AluSub;
                        imm_src  = ImmB;
                        pc_write = 1'b1;
                        pc_src   = taken ? PcImm : PcPlus4;
                        retired  = 1'b1;
                        state_d  = StFetch;
                    end
                    OpJal: begin
                        pc_jump = 1'b1;
                        imm_src = ImmJ;
                        state_d = StWriteback;
                    end
                    OpJalr: begin
                        // Target rs1+imm is formed here and consumed as PCsrc=ALU later.
                        pc_jump = 1'b1;
                        imm_src = ImmI;
                        alu_src = 1'b1;
                        state_d = StWriteback;
                    end
                    OpLui: begin
                        imm_src  = ImmU;
                        alu_src  = 1'b1;
                        alu_ctrl = AluPassB;
                        state_d  = StWriteback;
                    end
                    OpAuipc: begin
                        imm_src   = ImmU;
                        alu_src   = 1'b1;
                        alu_a_src = 1'b1;
                        state_d   = StWriteback;
                    end
                    default: begin
                        state_d = StTrap;
                        cause_d = CauseIllegal;
                    end
                endcase
            end
            StMemory: begin
                mem_req  = 1'b1;
                mem_size = funct3;
                data_we  = is_store;
                if (bus.mem_ready) begin
                    if (is_store) begin
                        pc_write = 1'b1;
                        retired  = 1'b1;
                        state_d  = StFetch;
                    end else begin
                        state_d = StWriteback;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CntLimit) begin
                        state_d = StTrap;
                        cause_d = CauseMem;
                    end
                end
            end
            StWriteback: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                retired   = 1'b1;
                if (opcode == OpJal || opcode == OpJalr) begin
                    result_src = ResPc4;
                end else if (opcode == OpLoad) begin
                    result_src = ResMem;
                end
                if (opcode == OpJal) begin
                    pc_src = PcImm;
                end else if (opcode == OpJalr) begin
                    pc_src = PcAlu;
                end
                state_d = StFetch;
            end
            StTrap: begin
                fault = 1'b1;
            end
            default: begin
                state_d = StFetch;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end

        // While rst is held every control reads its reset value.
        if (rst) begin
            mem_req     = 1'b0;
            data_we     = 1'b0;
            mem_size    = 3'b010;
            ir_write    = 1'b0;
            pc_write    = 1'b0;
            pc_src      = PcPlus4;
            reg_write   = 1'b0;
            result_src  = ResAlu;
            alu_src     = 1'b0;
            alu_a_src   = 1'b0;
            alu_ctrl    = AluAdd;
            imm_src     = ImmNone;
            pc_jump     = 1'b0;
            retired     = 1'b0;
            fault       = 1'b0;
            fault_cause = CauseNone;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            cnt_q   <= '0;
            cause_q <= CauseNone;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    assign bus.mem_req       = mem_req;
    assign bus.Data_WE       = data_we;
    assign bus.MemSize       = mem_size;
    assign bus.IRWrite       = ir_write;
    assign bus.PCWrite       = pc_write;
    assign bus.PCsrc         = pc_src;
    assign bus.RegWrite      = reg_write;
    assign bus.ResultSrc     = result_src;
    assign bus.ALUsrc        = alu_src;
    assign bus.ALUAsrc       = alu_a_src;
    assign bus.ALUctrl       = alu_ctrl;
    assign bus.ImmSrc        = imm_src;
    assign bus.PCJump        = pc_jump;
    assign bus.instr_retired = retired;
    assign bus.fault         = fault;
    assign bus.fault_cause   = fault_cause;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: the stimulus thread pushes one expected
// control vector per cycle, the monitor pops and compares on each falling edge.
module tb_multicycle_control_unit;
    typedef struct packed {
        logic       mem_req;
        logic       Data_WE;
        logic [2:0] MemSize;
        logic       IRWrite;
        logic       PCWrite;
        logic [1:0] PCsrc;
        logic       RegWrite;
        logic [1:0] ResultSrc;
        logic       ALUsrc;
        logic       ALUAsrc;
        logic [3:0] ALUctrl;
        logic [2:0] ImmSrc;
        logic       PCJump;
        logic       instr_retired;
        logic       fault;
        logic [1:0] fault_cause;
    } out_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cur_instr;

    out_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    multicycle_control_unit_if #(.Width(32), .ALUctrlWidth(4)) bus ();

    multicycle_control_unit #(
        .Width(32),
        .ALUctrlWidth(4),
        .MemTimeout(15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic out_t idle();
        out_t o;
        o         = '0;
        o.MemSize = 3'b010;
        o.ImmSrc  = 3'b011;
        return o;
    endfunction

    // One clock cycle: drive inputs just after the edge and queue the expected controls.
    task automatic cyc(input string name, input logic r, input logic rdy, input logic lt,
                       input out_t e);
        @(posedge clk);
        #1;
        rst           = r;
        bus.mem_ready = rdy;
        bus.LT        = lt;
        bus.instr     = cur_instr;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    task automatic fetch_decode(input string name, input logic [31:0] ins);
        out_t e;
        cur_instr = ins;
        e         = idle();
        e.mem_req = 1'b1;
        e.IRWrite = 1'b1;
        cyc({name, "_fetch"}, 1'b0, 1'b1, 1'b0, e);
        cyc({name, "_decode"}, 1'b0, 1'b0, 1'b0, idle());
    endtask

    task automatic wb(input string name, input logic [1:0] rs, input logic [1:0] pcs);
        out_t e;
        e               = idle();
        e.RegWrite      = 1'b1;
        e.PCWrite       = 1'b1;
        e.instr_retired = 1'b1;
        e.ResultSrc     = rs;
        e.PCsrc         = pcs;
        cyc({name, "_wb"}, 1'b0, 1'b0, 1'b0, e);
    endtask

    // Monitor: compare the DUT controls against the oldest queued expectation.
    always @(negedge clk) begin : monitor
        out_t  act;
        out_t  e;
        string n;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            n   = name_q.pop_front();
            act = {bus.mem_req, bus.Data_WE, bus.MemSize, bus.IRWrite, bus.PCWrite, bus.PCsrc,
                   bus.RegWrite, bus.ResultSrc, bus.ALUsrc, bus.ALUAsrc, bus.ALUctrl,
                   bus.ImmSrc, bus.PCJump, bus.instr_retired, bus.fault, bus.fault_cause};
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %h expected %h", n, act, e);
            end
        end
    end

    initial begin
        out_t e;
        rst           = 1'b1;
        cur_instr     = 32'h0;
        bus.instr     = 32'h0;
        bus.mem_ready = 1'b0;
        bus.EQ        = 1'b0;
        bus.LT        = 1'b0;
        bus.LTU       = 1'b0;

        // Reset: controls at reset values even with mem_ready high.
        cyc("reset0", 1'b1, 1'b0, 1'b0, idle());
        cyc("reset1", 1'b1, 1'b1, 1'b0, idle());

        // add x3,x1,x2
        fetch_decode("add", 32'h002081B3);
        cyc("add_ex", 1'b0, 1'b0, 1'b0, idle());
        wb("add", 2'b00, 2'b00);

        // sub x3,x1,x2: instr[30] selects sub
        fetch_decode("sub", 32'h402081B3);
        e = idle(); e.ALUctrl = 4'b0001;
        cyc("sub_ex", 1'b0, 1'b0, 1'b0, e);
        wb("sub", 2'b00, 2'b00);

        // addi with imm bit30 set: still add
        fetch_decode("addi", 32'h40008093);
        e = idle(); e.ALUsrc = 1'b1; e.ImmSrc = 3'b000;
        cyc("addi_ex", 1'b0, 1'b0, 1'b0, e);
        wb("addi", 2'b00, 2'b00);

        // lui x1,0x12345
        fetch_decode("lui", 32'h123450B7);
        e = idle(); e.ALUsrc = 1'b1; e.ImmSrc = 3'b100; e.ALUctrl = 4'b1010;
        cyc("lui_ex", 1'b0, 1'b0, 1'b0, e);
        wb("lui", 2'b00, 2'b00);

        // lw x3,0(x1) with 3 wait cycles in MEMORY
        fetch_decode("lw", 32'h0000A183);
        e = idle(); e.ALUsrc = 1'b1; e.ImmSrc = 3'b000;
        cyc("lw_ex", 1'b0, 1'b0, 1'b0, e);
        e = idle(); e.mem_req = 1'b1;
        for (int i = 0; i < 3; i++) cyc("lw_mem_wait", 1'b0, 1'b0, 1'b0, e);
        cyc("lw_mem_done", 1'b0, 1'b1, 1'b0, e);
        wb("lw", 2'b01, 2'b00);

        // sb x2,0(x1): byte size passed through, one wait then done
        fetch_decode("sb", 32'h00208023);
        e = idle(); e.ALUsrc = 1'b1; e.ImmSrc = 3'b001;
        cyc("sb_ex", 1'b0, 1'b0, 1'b0, e);
        e = idle(); e.mem_req = 1'b1; e.Data_WE = 1'b1; e.MemSize = 3'b000;
        cyc("sb_mem_wait", 1'b0, 1'b0, 1'b0, e);
        e.PCWrite = 1'b1; e.instr_retired = 1'b1;
        cyc("sb_mem_done", 1'b0, 1'b1, 1'b0, e);

        // bge x1,x2,8: taken with LT=0, not taken with LT=1
        fetch_decode("bge_t", 32'h0020D463);
        e = idle(); e.ALUctrl = 4'b0001; e.ImmSrc = 3'b010; e.PCWrite = 1'b1;
        e.instr_retired = 1'b1; e.PCsrc = 2'b01;
        cyc("bge_t_ex", 1'b0, 1'b0, 1'b0, e);
        fetch_decode("bge_nt", 32'h0020D463);
        e.PCsrc = 2'b00;
        cyc("bge_nt_ex", 1'b0, 1'b0, 1'b1, e);

        // jalr x1,0(x1)
        fetch_decode("jalr", 32'h000080E7);
        e = idle(); e.PCJump = 1'b1; e.ImmSrc = 3'b000; e.ALUsrc = 1'b1;
        cyc("jalr_ex", 1'b0, 1'b0, 1'b0, e);
        wb("jalr", 2'b10, 2'b10);

        // Illegal opcode: absorbing trap, then rst restores FETCH
        fetch_decode("ill", 32'h0000007F);
        e = idle(); e.fault = 1'b1; e.fault_cause = 2'b01;
        for (int i = 0; i < 20; i++) cyc("ill_trap", 1'b0, 1'b1, 1'b0, e);
        cyc("ill_rst", 1'b1, 1'b0, 1'b0, idle());
        e = idle(); e.mem_req = 1'b1;
        cyc("ill_refetch", 1'b0, 1'b0, 1'b0, e);

        // sw with mem_ready low: 15 cycles of Data_WE, then memory-timeout trap
        fetch_decode("sw_to", 32'h0020A023);
        e = idle(); e.ALUsrc = 1'b1; e.ImmSrc = 3'b001;
        cyc("sw_to_ex", 1'b0, 1'b0, 1'b0, e);
        e = idle(); e.mem_req = 1'b1; e.Data_WE = 1'b1;
        for (int i = 0; i < 15; i++) cyc("sw_to_mem", 1'b0, 1'b0, 1'b0, e);
        e = idle(); e.fault = 1'b1; e.fault_cause = 2'b10;
        for (int i = 0; i < 3; i++) cyc("sw_to_trap", 1'b0, 1'b0, 1'b0, e);
        cyc("sw_to_rst", 1'b1, 1'b0, 1'b0, idle());

        // sw interrupted by rst during MEMORY: no PCWrite, back to FETCH
        fetch_decode("sw_rst", 32'h0020A023);
        e = idle(); e.ALUsrc = 1'b1; e.ImmSrc = 3'b001;
        cyc("sw_rst_ex", 1'b0, 1'b0, 1'b0, e);
        e = idle(); e.mem_req = 1'b1; e.Data_WE = 1'b1;
        cyc("sw_rst_mem0", 1'b0, 1'b0, 1'b0, e);
        cyc("sw_rst_mem1", 1'b0, 1'b0, 1'b0, e);
        cyc("sw_rst_assert", 1'b1, 1'b1, 1'b0, idle());
        e = idle(); e.mem_req = 1'b1;
        cyc("sw_rst_after0", 1'b0, 1'b0, 1'b0, e);
        cyc("sw_rst_after1", 1'b0, 1'b0, 1'b0, e);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
